// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the MAR/MDR memory access unit
package mem_pkg;

  typedef enum logic [1:0] {
    MAU_IDLE,
    MAU_ACCESS,
    MAU_DONE
  } mau_state_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// rtl/mem_access_unit_if.sv - datapath request side and SRAM side of the access unit
interface mem_access_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic [DATA_W-1:0] bus_in;
  logic              LD_MAR;
  logic              LD_MDR;
  logic              req_valid;
  logic              req_we;
  logic              req_ready;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] MAR;
  logic [DATA_W-1:0] MDR;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              mem_ce_n;
  logic              mem_oe_n;
  logic              mem_we_n;

  modport master (
    output bus_in, LD_MAR, LD_MDR, req_valid, req_we, mem_rdata, mem_ready,
    input  req_ready, done, err, MAR, MDR, mem_addr, mem_wdata,
    input  mem_ce_n, mem_oe_n, mem_we_n
  );

  modport slave (
    input  bus_in, LD_MAR, LD_MDR, req_valid, req_we, mem_rdata, mem_ready,
    output req_ready, done, err, MAR, MDR, mem_addr, mem_wdata,
    output mem_ce_n, mem_oe_n, mem_we_n
  );

endinterface

// File: rtl/mem_access_unit_reg_n.sv
// rtl/mem_access_unit_reg_n.sv - W-bit register with synchronous reset and load enable
module reg_n #(
  parameter int W = 16
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MAR/MDR pair running multi-cycle SRAM accesses via req/done
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2,
  parameter int USE_READY   = 0,
  parameter int TIMEOUT     = 255
) (
  input  logic              Clk,
  input  logic              Reset,
  mem_access_unit_if.slave  bus
);

  localparam int CNT_MAX = (WAIT_CYCLES > TIMEOUT) ? WAIT_CYCLES : TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  mau_state_t        r_state;
  logic [CW-1:0]     r_cnt;
  logic              r_we;
  logic              r_ready;
  logic              r_done;
  logic              r_err;
  logic              r_ce_n;
  logic              r_oe_n;
  logic              r_we_n;

  logic              w_idle;
  logic              w_finish;
  logic              w_timeout;
  logic              w_mar_en;
  logic              w_mdr_en;
  logic [DATA_W-1:0] w_mdr_d;
  logic [ADDR_W-1:0] w_mar;
  logic [DATA_W-1:0] w_mdr;

  always_comb begin
    w_idle    = (r_state == MAU_IDLE);
    w_timeout = 1'b0;
    if (USE_READY != 0) begin
      w_finish  = bus.mem_ready;
      w_timeout = !bus.mem_ready && (r_cnt == CW'(TIMEOUT - 1));
    end else begin
      w_finish  = (r_cnt == CW'(WAIT_CYCLES - 1));
    end
    // A request in the same cycle as a load wins; the access uses the held MAR/MDR.
    w_mar_en = w_idle && bus.LD_MAR && !bus.req_valid;
    w_mdr_en = w_idle && bus.LD_MDR && !bus.req_valid;
    w_mdr_d  = bus.bus_in;
    if ((r_state == MAU_ACCESS) && w_finish && !r_we) begin
      w_mdr_en = 1'b1;
      w_mdr_d  = bus.mem_rdata;
    end
  end

  reg_n #(.W(ADDR_W)) u_mar (
    .Clk   (Clk),
    .Reset (Reset),
    .i_en  (w_mar_en),
    .i_d   (bus.bus_in[ADDR_W-1:0]),
    .o_q   (w_mar)
  );

  reg_n #(.W(DATA_W)) u_mdr (
    .Clk   (Clk),
    .Reset (Reset),
    .i_en  (w_mdr_en),
    .i_d   (w_mdr_d),
    .o_q   (w_mdr)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= MAU_IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
    end else begin
      case (r_state)
        MAU_IDLE: begin
          if (bus.req_valid) begin
            r_state <= MAU_ACCESS;
            r_we    <= bus.req_we;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_ce_n  <= 1'b0;
            r_oe_n  <= bus.req_we;
            r_we_n  <= !bus.req_we;
          end
        end
        MAU_ACCESS: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_finish || w_timeout) begin
            r_state <= MAU_DONE;
            r_done  <= 1'b1;
            r_err   <= w_timeout;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
          end
        end
        MAU_DONE: begin
          r_state <= MAU_IDLE;
          r_done  <= 1'b0;
          r_err   <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= MAU_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.MAR       = w_mar;
  assign bus.MDR       = w_mdr;
  assign bus.mem_addr  = w_mar;
  assign bus.mem_wdata = w_mdr;
  assign bus.mem_ce_n  = r_ce_n;
  assign bus.mem_oe_n  = r_oe_n;
  assign bus.mem_we_n  = r_we_n;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - checks a fixed-wait unit and a ready/timeout unit against a transaction model
module tb_mem_access_unit;

  logic Clk;
  logic Reset;
  int   checks;
  int   failures;
  int   cyc;
  bit   mvalid;

  mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) ifa ();
  mem_access_unit_if #(.ADDR_W(16), .DATA_W(16)) ifb ();

  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2), .USE_READY(0), .TIMEOUT(255)) dut_a (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifa)
  );

  mem_access_unit #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2), .USE_READY(1), .TIMEOUT(8)) dut_b (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (ifb)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One outstanding access: accepted in cycle start, last memory cycle fin (-1 while unknown).
  typedef struct {
    bit          active;
    int          start;
    int          fin;
    bit          we;
    bit          er;
    logic [15:0] mar;
    logic [15:0] mdr;
  } mdl_t;

  mdl_t ma;
  mdl_t mb;

  function automatic mdl_t step(mdl_t m, int c, bit rst, bit ldmar, bit ldmdr, bit rv, bit rwe,
                                logic [15:0] bus, logic [15:0] rdata, bit rdy,
                                int waitc, bit use_rdy, int tmo);
    mdl_t n = m;
    if (rst) begin
      n.active = 0; n.start = 0; n.fin = -1; n.we = 0; n.er = 0; n.mar = 0; n.mdr = 0;
      return n;
    end
    if (!n.active) begin
      if (rv) begin
        n.active = 1; n.start = c; n.we = rwe; n.er = 0;
        n.fin = use_rdy ? -1 : c + waitc;
      end else begin
        if (ldmar) n.mar = bus;
        if (ldmdr) n.mdr = bus;
      end
      return n;
    end
    if (use_rdy && n.fin < 0 && c > n.start) begin
      if (rdy) n.fin = c;
      else if (c - n.start == tmo) begin n.fin = c; n.er = 1; end
    end
    if (n.fin >= 0 && c == n.fin && !n.we && !n.er) n.mdr = rdata;
    if (n.fin >= 0 && c == n.fin + 1) n.active = 0;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cmp_dut(input string tag, input mdl_t m, input int c,
                         input logic [15:0] mar, input logic [15:0] mdr,
                         input logic [15:0] maddr, input logic [15:0] wdata,
                         input logic rdy, input logic dn, input logic er,
                         input logic ce, input logic oe, input logic we);
    bit acc;
    bit dne;
    acc = m.active && c > m.start && (m.fin < 0 || c <= m.fin);
    dne = m.active && m.fin >= 0 && c == m.fin + 1;
    chk($sformatf("%s.MAR c%0d", tag, c), {16'h0, mar}, {16'h0, m.mar});
    chk($sformatf("%s.MDR c%0d", tag, c), {16'h0, mdr}, {16'h0, m.mdr});
    chk($sformatf("%s.mem_addr c%0d", tag, c), {16'h0, maddr}, {16'h0, m.mar});
    chk($sformatf("%s.mem_wdata c%0d", tag, c), {16'h0, wdata}, {16'h0, m.mdr});
    chk($sformatf("%s.req_ready c%0d", tag, c), {31'h0, rdy}, {31'h0, !m.active});
    chk($sformatf("%s.done c%0d", tag, c), {31'h0, dn}, {31'h0, dne});
    chk($sformatf("%s.err c%0d", tag, c), {31'h0, er}, {31'h0, dne && m.er});
    chk($sformatf("%s.ce_n c%0d", tag, c), {31'h0, ce}, {31'h0, !acc});
    chk($sformatf("%s.oe_n c%0d", tag, c), {31'h0, oe}, {31'h0, !(acc && !m.we)});
    chk($sformatf("%s.we_n c%0d", tag, c), {31'h0, we}, {31'h0, !(acc && m.we)});
  endtask

  always @(posedge Clk) begin
    ma = step(ma, cyc, Reset, ifa.LD_MAR, ifa.LD_MDR, ifa.req_valid, ifa.req_we,
              ifa.bus_in, ifa.mem_rdata, ifa.mem_ready, 2, 1'b0, 255);
    mb = step(mb, cyc, Reset, ifb.LD_MAR, ifb.LD_MDR, ifb.req_valid, ifb.req_we,
              ifb.bus_in, ifb.mem_rdata, ifb.mem_ready, 2, 1'b1, 8);
    if (Reset) mvalid = 1;
    cyc++;
  end

  always @(negedge Clk) begin
    if (mvalid) begin
      cmp_dut("a", ma, cyc, ifa.MAR, ifa.MDR, ifa.mem_addr, ifa.mem_wdata, ifa.req_ready,
              ifa.done, ifa.err, ifa.mem_ce_n, ifa.mem_oe_n, ifa.mem_we_n);
      cmp_dut("b", mb, cyc, ifb.MAR, ifb.MDR, ifb.mem_addr, ifb.mem_wdata, ifb.req_ready,
              ifb.done, ifb.err, ifb.mem_ce_n, ifb.mem_oe_n, ifb.mem_we_n);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; mvalid = 0;
    ifa.bus_in = '0; ifa.LD_MAR = 0; ifa.LD_MDR = 0; ifa.req_valid = 0; ifa.req_we = 0;
    ifa.mem_rdata = '0; ifa.mem_ready = 0;
    ifb.bus_in = '0; ifb.LD_MAR = 0; ifb.LD_MDR = 0; ifb.req_valid = 0; ifb.req_we = 0;
    ifb.mem_rdata = '0; ifb.mem_ready = 0;
    Reset = 1;
    tick(); tick();
    chk("rst.MAR", {16'h0, ifa.MAR}, 32'h0);
    chk("rst.MDR", {16'h0, ifa.MDR}, 32'h0);
    chk("rst.req_ready", {31'h0, ifa.req_ready}, 32'h1);
    chk("rst.done_err", {30'h0, ifa.done, ifa.err}, 32'h0);
    chk("rst.strobes", {29'h0, ifa.mem_ce_n, ifa.mem_oe_n, ifa.mem_we_n}, 32'h7);
    Reset = 0;

    // fixed-wait read
    ifa.LD_MAR = 1; ifa.bus_in = 16'h3000; tick();
    ifa.LD_MAR = 0; ifa.req_valid = 1; ifa.req_we = 0; ifa.mem_rdata = 16'hBEEF; tick();
    ifa.req_valid = 0;
    chk("rd.c1.ce_oe", {30'h0, ifa.mem_ce_n, ifa.mem_oe_n}, 32'h0);
    chk("rd.c1.we_n", {31'h0, ifa.mem_we_n}, 32'h1);
    chk("rd.c1.mem_addr", {16'h0, ifa.mem_addr}, 32'h3000);
    tick();
    chk("rd.c2.ce_oe", {30'h0, ifa.mem_ce_n, ifa.mem_oe_n}, 32'h0);
    tick();
    chk("rd.c3.done", {31'h0, ifa.done}, 32'h1);
    chk("rd.c3.MDR", {16'h0, ifa.MDR}, 32'hBEEF);
    chk("rd.c3.req_ready", {31'h0, ifa.req_ready}, 32'h0);
    chk("rd.c3.ce_n", {31'h0, ifa.mem_ce_n}, 32'h1);
    tick();
    chk("rd.c4.req_ready", {31'h0, ifa.req_ready}, 32'h1);
    chk("rd.c4.done", {31'h0, ifa.done}, 32'h0);

    // fixed-wait write
    ifa.LD_MAR = 1; ifa.bus_in = 16'h0040; tick();
    ifa.LD_MAR = 0; ifa.LD_MDR = 1; ifa.bus_in = 16'h1234; tick();
    ifa.LD_MDR = 0; ifa.req_valid = 1; ifa.req_we = 1; tick();
    ifa.req_valid = 0;
    chk("wr.c1.we_oe", {30'h0, ifa.mem_we_n, ifa.mem_oe_n}, 32'h1);
    chk("wr.c1.mem_addr", {16'h0, ifa.mem_addr}, 32'h0040);
    chk("wr.c1.mem_wdata", {16'h0, ifa.mem_wdata}, 32'h1234);
    tick();
    chk("wr.c2.we_n", {31'h0, ifa.mem_we_n}, 32'h0);
    tick();
    chk("wr.c3.done", {31'h0, ifa.done}, 32'h1);
    chk("wr.c3.MDR", {16'h0, ifa.MDR}, 32'h1234);
    tick();

    // busy guard: loads and requests during accept/ACCESS/DONE are ignored
    ifa.req_we = 0; ifa.mem_rdata = 16'h5A5A;
    ifa.req_valid = 1; ifa.LD_MAR = 1; ifa.bus_in = 16'hFFFF;
    tick(); tick(); tick();
    chk("busy.c3.MAR", {16'h0, ifa.MAR}, 32'h0040);
    ifa.req_valid = 0; ifa.LD_MAR = 0;
    tick();
    chk("busy.c4.MAR", {16'h0, ifa.MAR}, 32'h0040);
    chk("busy.c4.MDR", {16'h0, ifa.MDR}, 32'h5A5A);
    tick();
    chk("busy.c5.ce_n", {31'h0, ifa.mem_ce_n}, 32'h1);

    // back-to-back requests: one accepted per four cycles
    ifa.req_valid = 1; ifa.mem_rdata = 16'h0F0F;
    repeat (8) tick();
    ifa.req_valid = 0;
    repeat (4) tick();

    // reset in first ACCESS cycle
    ifa.mem_rdata = 16'h1111; ifa.req_valid = 1; tick();
    ifa.req_valid = 0;
    chk("rstmid.c1.oe_n", {31'h0, ifa.mem_oe_n}, 32'h0);
    Reset = 1; tick(); Reset = 0;
    chk("rstmid.strobes", {29'h0, ifa.mem_ce_n, ifa.mem_oe_n, ifa.mem_we_n}, 32'h7);
    chk("rstmid.done", {31'h0, ifa.done}, 32'h0);
    chk("rstmid.req_ready", {31'h0, ifa.req_ready}, 32'h1);
    chk("rstmid.MDR", {16'h0, ifa.MDR}, 32'h0);
    tick();
    chk("rstmid.next.done", {31'h0, ifa.done}, 32'h0);

    // ready-driven unit: completion after 5 ACCESS cycles
    ifb.LD_MAR = 1; ifb.bus_in = 16'h0077; tick();
    ifb.LD_MAR = 0; ifb.LD_MDR = 1; ifb.bus_in = 16'hAAAA; tick();
    ifb.LD_MDR = 0; ifb.req_valid = 1; ifb.req_we = 0; ifb.mem_rdata = 16'hC0DE; tick();
    ifb.req_valid = 0;
    repeat (4) tick();
    chk("rdy.c5.ce_n", {31'h0, ifb.mem_ce_n}, 32'h0);
    ifb.mem_ready = 1; tick();
    chk("rdy.c6.done_err", {30'h0, ifb.done, ifb.err}, 32'h2);
    chk("rdy.c6.MDR", {16'h0, ifb.MDR}, 32'hC0DE);
    ifb.mem_ready = 0; tick();
    chk("rdy.c7.req_ready", {31'h0, ifb.req_ready}, 32'h1);

    // timeout after 8 ACCESS cycles
    ifb.mem_rdata = 16'hDEAD; ifb.req_valid = 1; tick();
    ifb.req_valid = 0;
    repeat (7) tick();
    chk("tmo.c8.ce_n", {31'h0, ifb.mem_ce_n}, 32'h0);
    chk("tmo.c8.done", {31'h0, ifb.done}, 32'h0);
    tick();
    chk("tmo.c9.done_err", {30'h0, ifb.done, ifb.err}, 32'h3);
    chk("tmo.c9.MDR", {16'h0, ifb.MDR}, 32'hC0DE);
    tick();
    chk("tmo.c10.done_err", {30'h0, ifb.done, ifb.err}, 32'h0);

    // ready sampled in the first ACCESS cycle of a write
    ifb.req_valid = 1; ifb.req_we = 1; tick();
    ifb.req_valid = 0; ifb.mem_ready = 1;
    chk("rdy1.c1.we_n", {31'h0, ifb.mem_we_n}, 32'h0);
    tick();
    ifb.mem_ready = 0;
    chk("rdy1.c2.done_err", {30'h0, ifb.done, ifb.err}, 32'h2);
    chk("rdy1.c2.MDR", {16'h0, ifb.MDR}, 32'hC0DE);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
